// File: rtl/traffic_pkg.sv
// ============================================================================
// Module  : traffic_pkg
// Brief   : Shared state encoding and light patterns for the two-road
//           intersection controller. NIGHT exists only with NIGHT_MODE_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package traffic_pkg;

    localparam int STATE_W = 3;
    localparam int COUNT_W = 7;
    localparam int LIGHT_W = 3;

    typedef enum logic [STATE_W-1:0] {
        MAIN_GREEN  = 3'd0,
        MAIN_YELLOW = 3'd1,
        SIDE_GREEN  = 3'd2,
`ifdef NIGHT_MODE_EN
        SIDE_YELLOW = 3'd3,
        NIGHT       = 3'd4
`else
        SIDE_YELLOW = 3'd3
`endif
    } state_t;

    // Light patterns are {R,Y,G}
    localparam logic [LIGHT_W-1:0] LT_RED = 3'b100;
    localparam logic [LIGHT_W-1:0] LT_YEL = 3'b010;
    localparam logic [LIGHT_W-1:0] LT_GRN = 3'b001;
    localparam logic [LIGHT_W-1:0] LT_OFF = 3'b000;

    function automatic logic [COUNT_W-1:0] to_count(input int ticks);
        return ticks[COUNT_W-1:0];
    endfunction

endpackage : traffic_pkg

`default_nettype wire

// File: rtl/tick_gen.sv
// ============================================================================
// Module  : tick_gen
// Brief   : Free-running divider producing a registered one-cycle enable
//           every DIV clocks; no derived clock is generated.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tick_gen #(
    parameter int DIV = 50000000
) (
    input  logic CLK_50M,
    input  logic CLR,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] C_LAST = CW'(DIV - 1);

    logic [CW-1:0] r_cnt;
    logic          r_tick;
    logic          w_wrap;

    assign w_wrap = (r_cnt == C_LAST);

    always_ff @(posedge CLK_50M or posedge CLR) begin
        if (CLR) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else begin
            r_cnt  <= w_wrap ? '0 : r_cnt + 1'b1;
            r_tick <= w_wrap;
        end
    end

    assign tick = r_tick;

endmodule : tick_gen

`default_nettype wire

// File: rtl/traffic_light_ctrl.sv
// ============================================================================
// Module  : traffic_light_ctrl
// Brief   : Main/side intersection controller: 1 Hz tick, Moore phase FSM,
//           latched side-road requests, seconds countdown. Optional night
//           blink mode via NIGHT_MODE_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module traffic_light_ctrl
    import traffic_pkg::*;
#(
    parameter int CLK_FREQ     = 50000000,
    parameter int TICK_FREQ    = 1,
    parameter int T_GREEN      = 25,
    parameter int T_SIDE_GREEN = 15,
    parameter int T_YELLOW     = 5
) (
    input  logic         CLK_50M,
    input  logic         CLR,
    input  logic         side_req,
`ifdef NIGHT_MODE_EN
    input  logic         night,
`endif
    output logic [2:0]   main_light,
    output logic [2:0]   side_light,
    output logic [6:0]   count_sec,
    output logic         tick
);

    localparam int DIV = CLK_FREQ / TICK_FREQ;

    localparam logic [COUNT_W-1:0] C_T_GREEN  = to_count(T_GREEN);
    localparam logic [COUNT_W-1:0] C_T_SGREEN = to_count(T_SIDE_GREEN);
    localparam logic [COUNT_W-1:0] C_T_YELLOW = to_count(T_YELLOW);

    logic                 w_tick;

    state_t               r_state;
    logic [COUNT_W-1:0]   r_count;
    logic [LIGHT_W-1:0]   r_main;
    logic [LIGHT_W-1:0]   r_side;
    logic                 r_req;

    state_t               w_state_nxt;
    logic [COUNT_W-1:0]   w_count_nxt;
    logic [LIGHT_W-1:0]   w_main_nxt;
    logic [LIGHT_W-1:0]   w_side_nxt;
    logic                 w_serve;

    tick_gen #(
        .DIV     (DIV)
    ) u_tick_gen (
        .CLK_50M (CLK_50M),
        .CLR     (CLR),
        .tick    (w_tick)
    );

    always_ff @(posedge CLK_50M or posedge CLR) begin
        if (CLR) begin
            r_state <= MAIN_GREEN;
            r_count <= C_T_GREEN;
            r_main  <= LT_GRN;
            r_side  <= LT_RED;
            r_req   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            r_main  <= w_main_nxt;
            r_side  <= w_side_nxt;
            // Entering side green serves the waiting vehicle, so clear beats set
            r_req   <= (r_req | side_req) & ~w_serve;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_main_nxt  = r_main;
        w_side_nxt  = r_side;

        case (r_state)
            MAIN_GREEN, MAIN_YELLOW, SIDE_GREEN, SIDE_YELLOW
`ifdef NIGHT_MODE_EN
            , NIGHT
`endif
            : begin
                if (w_tick) begin
`ifdef NIGHT_MODE_EN
                    if (night) begin
                        w_state_nxt = NIGHT;
                        w_count_nxt = '0;
                        if (r_state == NIGHT && r_main == LT_YEL) begin
                            w_main_nxt = LT_OFF;
                            w_side_nxt = LT_OFF;
                        end else begin
                            w_main_nxt = LT_YEL;
                            w_side_nxt = LT_YEL;
                        end
                    end else if (r_state == NIGHT) begin
                        w_state_nxt = MAIN_GREEN;
                        w_count_nxt = C_T_GREEN;
                        w_main_nxt  = LT_GRN;
                        w_side_nxt  = LT_RED;
                    end else
`endif
                    if (r_count > 7'd1) begin
                        w_count_nxt = r_count - 7'd1;
                    end else begin
                        case (r_state)
                            MAIN_GREEN: begin
                                // Without a pending request main green extends indefinitely
                                if (r_req) begin
                                    w_state_nxt = MAIN_YELLOW;
                                    w_count_nxt = C_T_YELLOW;
                                    w_main_nxt  = LT_YEL;
                                    w_side_nxt  = LT_RED;
                                end
                            end
                            MAIN_YELLOW: begin
                                w_state_nxt = SIDE_GREEN;
                                w_count_nxt = C_T_SGREEN;
                                w_main_nxt  = LT_RED;
                                w_side_nxt  = LT_GRN;
                            end
                            SIDE_GREEN: begin
                                w_state_nxt = SIDE_YELLOW;
                                w_count_nxt = C_T_YELLOW;
                                w_main_nxt  = LT_RED;
                                w_side_nxt  = LT_YEL;
                            end
                            default: begin
                                w_state_nxt = MAIN_GREEN;
                                w_count_nxt = C_T_GREEN;
                                w_main_nxt  = LT_GRN;
                                w_side_nxt  = LT_RED;
                            end
                        endcase
                    end
                end
            end
            default: begin
                // Corrupted encoding: recover through yellow, side held red
                w_state_nxt = MAIN_YELLOW;
                w_count_nxt = C_T_YELLOW;
                w_main_nxt  = LT_YEL;
                w_side_nxt  = LT_RED;
            end
        endcase
    end

    assign w_serve = (w_state_nxt == SIDE_GREEN) && (r_state != SIDE_GREEN);

    assign main_light = r_main;
    assign side_light = r_side;
    assign count_sec  = r_count;
    assign tick       = w_tick;

endmodule : traffic_light_ctrl

`default_nettype wire

// File: tb/tb_traffic_light_ctrl.sv
// ============================================================================
// Module  : tb_traffic_light_ctrl
// Brief   : Directed self-checking bench for traffic_light_ctrl (DIV=10,
//           T_GREEN=3, T_SIDE_GREEN=2, T_YELLOW=2). Night test with NIGHT_MODE_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_traffic_light_ctrl;

    logic       CLK_50M = 1'b0;
    logic       CLR     = 1'b1;
    logic       side_req = 1'b0;
`ifdef NIGHT_MODE_EN
    logic       night   = 1'b0;
`endif
    logic [2:0] main_light;
    logic [2:0] side_light;
    logic [6:0] count_sec;
    logic       tick;

    int checks   = 0;
    int failures = 0;

    always #5 CLK_50M = ~CLK_50M;

    traffic_light_ctrl #(
        .CLK_FREQ     (10),
        .TICK_FREQ    (1),
        .T_GREEN      (3),
        .T_SIDE_GREEN (2),
        .T_YELLOW     (2)
    ) dut (
        .CLK_50M    (CLK_50M),
        .CLR        (CLR),
        .side_req   (side_req),
`ifdef NIGHT_MODE_EN
        .night      (night),
`endif
        .main_light (main_light),
        .side_light (side_light),
        .count_sec  (count_sec),
        .tick       (tick)
    );

    task automatic step();
        @(negedge CLK_50M);
    endtask

    // Advances negedge by negedge until tick is seen; cyc = cycles advanced.
    task automatic wait_tick(output int cyc);
        bit seen;
        seen = 1'b0;
        cyc  = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            cyc++;
            if (tick === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        checks++;
        if (seen !== 1'b1) begin
            failures++;
            $display("FAIL tick_timeout: tick=%b after %0d cycles, required 1", tick, cyc);
        end
    endtask

    // Reset held two edges, released at a negedge; next posedge is the first after release.
    task automatic do_reset();
        CLR      = 1'b1;
        side_req = 1'b0;
        step();
        step();
        CLR = 1'b0;
    endtask

    task automatic test_reset();
        step();
        checks++;
        if ({main_light, side_light} !== 6'b001_100) begin
            failures++;
            $display("FAIL reset_lights: got %b_%b, required 001_100", main_light, side_light);
        end
        checks++;
        if (count_sec !== 7'd3) begin
            failures++;
            $display("FAIL reset_count: got %0d, required 3", count_sec);
        end
        checks++;
        if (tick !== 1'b0) begin
            failures++;
            $display("FAIL reset_tick: got %b, required 0", tick);
        end
    endtask

    task automatic test_tick_timing();
        int cyc;
        do_reset();
        wait_tick(cyc);
        checks++;
        if (cyc !== 10) begin
            failures++;
            $display("FAIL first_tick_cycle: got %0d, required 10", cyc);
        end
        checks++;
        if (count_sec !== 7'd3) begin
            failures++;
            $display("FAIL count_before_edge: got %0d, required 3", count_sec);
        end
        step();
        checks++;
        if (count_sec !== 7'd2 || tick !== 1'b0) begin
            failures++;
            $display("FAIL count_tick1: got count=%0d tick=%b, required count=2 tick=0", count_sec, tick);
        end
        wait_tick(cyc);
        checks++;
        if (cyc !== 9) begin
            failures++;
            $display("FAIL tick_period: got %0d, required 9 after post-tick step", cyc);
        end
        step();
        checks++;
        if (count_sec !== 7'd1) begin
            failures++;
            $display("FAIL count_tick2: got %0d, required 1", count_sec);
        end
        for (int k = 0; k < 2; k++) begin
            wait_tick(cyc);
            step();
            checks++;
            if (count_sec !== 7'd1 || {main_light, side_light} !== 6'b001_100) begin
                failures++;
                $display("FAIL green_hold%0d: got count=%0d lights=%b_%b, required 1 001_100",
                         k, count_sec, main_light, side_light);
            end
        end
    endtask

    task automatic test_side_cycle();
        logic [12:0] exp_tab [12];
        int cyc;
        exp_tab = '{{3'b001, 3'b100, 7'd2}, {3'b001, 3'b100, 7'd1},
                    {3'b010, 3'b100, 7'd2}, {3'b010, 3'b100, 7'd1},
                    {3'b100, 3'b001, 7'd2}, {3'b100, 3'b001, 7'd1},
                    {3'b100, 3'b010, 7'd2}, {3'b100, 3'b010, 7'd1},
                    {3'b001, 3'b100, 7'd3}, {3'b001, 3'b100, 7'd2},
                    {3'b001, 3'b100, 7'd1}, {3'b001, 3'b100, 7'd1}};
        do_reset();
        side_req = 1'b1;
        step();
        side_req = 1'b0;
        for (int k = 0; k < 12; k++) begin
            wait_tick(cyc);
            step();
            checks++;
            if ({main_light, side_light, count_sec} !== exp_tab[k]) begin
                failures++;
                $display("FAIL side_cycle_t%0d: got %b_%b cnt=%0d, required %b_%b cnt=%0d", k + 1,
                         main_light, side_light, count_sec,
                         exp_tab[k][12:10], exp_tab[k][9:7], exp_tab[k][6:0]);
            end
        end
    endtask

    // Continues from the held main green left by test_side_cycle.
    task automatic test_req_held();
        logic [12:0] exp_tab [10];
        int cyc;
        exp_tab = '{{3'b010, 3'b100, 7'd2}, {3'b010, 3'b100, 7'd1},
                    {3'b100, 3'b001, 7'd2}, {3'b100, 3'b001, 7'd1},
                    {3'b100, 3'b010, 7'd2}, {3'b100, 3'b010, 7'd1},
                    {3'b001, 3'b100, 7'd3}, {3'b001, 3'b100, 7'd2},
                    {3'b001, 3'b100, 7'd1}, {3'b010, 3'b100, 7'd2}};
        side_req = 1'b1;
        for (int k = 0; k < 10; k++) begin
            wait_tick(cyc);
            step();
            checks++;
            if ({main_light, side_light, count_sec} !== exp_tab[k]) begin
                failures++;
                $display("FAIL req_held_t%0d: got %b_%b cnt=%0d, required %b_%b cnt=%0d", k + 1,
                         main_light, side_light, count_sec,
                         exp_tab[k][12:10], exp_tab[k][9:7], exp_tab[k][6:0]);
            end
            if (k == 2) begin
                step();
                side_req = 1'b0;
            end
        end
    endtask

    task automatic test_clr_mid();
        int cyc;
        do_reset();
        side_req = 1'b1;
        step();
        side_req = 1'b0;
        for (int k = 0; k < 5; k++) wait_tick(cyc);
        step();
        checks++;
        if ({main_light, side_light} !== 6'b100_001) begin
            failures++;
            $display("FAIL clr_setup: got %b_%b, required 100_001", main_light, side_light);
        end
        step();
        step();
        #2 CLR = 1'b1;
        #1;
        checks++;
        if ({main_light, side_light, count_sec, tick} !== {6'b001_100, 7'd3, 1'b0}) begin
            failures++;
            $display("FAIL clr_async: got %b_%b cnt=%0d tick=%b, required 001_100 cnt=3 tick=0",
                     main_light, side_light, count_sec, tick);
        end
        step();
        CLR = 1'b0;
        wait_tick(cyc);
        checks++;
        if (cyc !== 10) begin
            failures++;
            $display("FAIL clr_tick_restart: got %0d, required 10", cyc);
        end
        for (int k = 0; k < 3; k++) begin
            wait_tick(cyc);
        end
        step();
        checks++;
        if ({main_light, count_sec} !== {3'b001, 7'd1}) begin
            failures++;
            $display("FAIL clr_latch_cleared: got main=%b cnt=%0d, required 001 cnt=1",
                     main_light, count_sec);
        end
    endtask

`ifdef NIGHT_MODE_EN
    task automatic test_night();
        logic [2:0] exp_y [3];
        int cyc;
        exp_y = '{3'b010, 3'b000, 3'b010};
        do_reset();
        night = 1'b1;
        for (int k = 0; k < 3; k++) begin
            wait_tick(cyc);
            step();
            checks++;
            if (main_light !== exp_y[k] || side_light !== exp_y[k] || count_sec !== 7'd0) begin
                failures++;
                $display("FAIL night_blink%0d: got %b_%b cnt=%0d, required %b_%b cnt=0",
                         k, main_light, side_light, count_sec, exp_y[k], exp_y[k]);
            end
        end
        night = 1'b0;
        wait_tick(cyc);
        step();
        checks++;
        if ({main_light, side_light, count_sec} !== {6'b001_100, 7'd3}) begin
            failures++;
            $display("FAIL night_exit: got %b_%b cnt=%0d, required 001_100 cnt=3",
                     main_light, side_light, count_sec);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_tick_timing();
        test_side_cycle();
        test_req_held();
        test_clr_mid();
`ifdef NIGHT_MODE_EN
        test_night();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_traffic_light_ctrl

`default_nettype wire
